// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader
// Read-side master for the synchronous FIFO. Issues FIFO reads, absorbs the
// FIFO's one-cycle registered read latency, and presents the words in order on
// a valid/ready stream through a 2-entry output buffer. With m_ready held high
// it sustains one word per cycle.
//
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   enable          1 = keep issuing FIFO reads; 0 = stop issuing, drain
//   fifo_rd_en      read request to the FIFO
//   fifo_dout       FIFO read data, valid the cycle after an accepted read
//   fifo_empty      FIFO empty flag
//   fifo_underflow  FIFO underflow flag
//   m_valid/m_data  stream word (straight from the buffer registers)
//   m_ready         downstream accept
//   words_out       stream handshakes since reset (wraps)
//   idle            buffer empty and no read in flight
//   err_underflow   sticky, set whenever fifo_underflow is seen
module fifo_stream_reader #(
    parameter int DATA_WIDTH = 16,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    input  logic                  fifo_empty,
    input  logic                  fifo_underflow,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    input  logic                  m_ready,
    output logic [CNT_WIDTH-1:0]  words_out,
    output logic                  idle,
    output logic                  err_underflow
);

    logic [DATA_WIDTH-1:0] head_q;   // buffer slot 0, always the oldest word
    logic [DATA_WIDTH-1:0] tail_q;   // buffer slot 1
    logic [1:0]            buf_cnt;
    logic                  inflight; // a read was issued last cycle
    logic                  pop;
    logic [2:0]            occ_next;

    assign m_valid = (buf_cnt != 2'd0);
    assign m_data  = head_q;
    assign idle    = (buf_cnt == 2'd0) && !inflight;
    assign pop     = m_valid && m_ready;

    // Words that will be held once this cycle's pop and capture settle. A new
    // read is only issued if its data is guaranteed a free slot on arrival.
    // pop implies buf_cnt >= 1, so this never goes negative.
    assign occ_next   = {1'b0, buf_cnt} + {2'b00, inflight} - {2'b00, pop};
    assign fifo_rd_en = !rst && enable && !fifo_empty && (occ_next < 3'd2);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q        <= '0;
            tail_q        <= '0;
            buf_cnt       <= 2'd0;
            inflight      <= 1'b0;
            words_out     <= '0;
            err_underflow <= 1'b0;
        end else begin
            inflight <= fifo_rd_en;
            if (fifo_underflow)
                err_underflow <= 1'b1;
            if (pop)
                words_out <= words_out + CNT_WIDTH'(1);

            case ({inflight, pop})
                2'b10: begin
                    // capture only: append at the tail
                    if (buf_cnt == 2'd0)
                        head_q <= fifo_dout;
                    else
                        tail_q <= fifo_dout;
                    buf_cnt <= buf_cnt + 2'd1;
                end
                2'b01: begin
                    // pop only: shift the tail forward
                    head_q  <= tail_q;
                    buf_cnt <= buf_cnt - 2'd1;
                end
                2'b11: begin
                    // pop and capture together: count unchanged, order kept
                    if (buf_cnt == 2'd2) begin
                        head_q <= tail_q;
                        tail_q <= fifo_dout;
                    end else begin
                        head_q <= fifo_dout;
                    end
                end
                default: ;
            endcase
        end
    end

    // The issue rule must make a capture into a full, non-draining buffer
    // impossible.
    a_no_overrun: assert property (@(posedge clk) disable iff (rst)
        !(inflight && buf_cnt == 2'd2 && !pop));

endmodule

// File: tb/tb_fifo_stream_reader.sv
module tb_fifo_stream_reader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        fifo_rd_en;
    logic [15:0] fifo_dout = '0;
    logic        fifo_empty;
    logic        fifo_underflow = 1'b0;
    logic        m_valid;
    logic [15:0] m_data;
    logic        m_ready = 1'b0;
    logic [31:0] words_out;
    logic        idle;
    logic        err_underflow;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    fifo_stream_reader #(.DATA_WIDTH(16), .CNT_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .enable(enable), .fifo_rd_en(fifo_rd_en),
        .fifo_dout(fifo_dout), .fifo_empty(fifo_empty),
        .fifo_underflow(fifo_underflow), .m_valid(m_valid), .m_data(m_data),
        .m_ready(m_ready), .words_out(words_out), .idle(idle),
        .err_underflow(err_underflow)
    );

    // ---------------- FIFO model: registered read, one-cycle latency -------
    logic [15:0] mem [256];
    logic [7:0]  wr_ptr = '0;
    logic [7:0]  rd_ptr = '0;
    logic        fflush = 1'b0;
    int          rd_pulses = 0;

    assign fifo_empty = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        if (fflush)
            rd_ptr <= wr_ptr;
        else if (fifo_rd_en && wr_ptr != rd_ptr) begin
            fifo_dout <= mem[rd_ptr];
            rd_ptr    <= rd_ptr + 8'd1;
            rd_pulses <= rd_pulses + 1;
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        tests++;
        if (act !== exp_v) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp_v, $time);
        end
    endtask

    task automatic push(input logic [15:0] w);
        mem[wr_ptr] = w;
        wr_ptr = wr_ptr + 8'd1;
    endtask

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic smp;
        @(negedge clk);
    endtask

    task automatic reset_dut;
        rst = 1'b1;
        fflush = 1'b1;
        enable = 1'b0;
        m_ready = 1'b0;
        fifo_underflow = 1'b0;
        cyc();
        cyc();
        fflush = 1'b0;
        cyc();
        rst = 1'b0;
    endtask

    // ---------------- Stream monitor / scoreboard --------------------------
    // Every word read from the FIFO must come out exactly once, in read order;
    // words read but not yet delivered are what the reader holds.
    logic [7:0]  del_ptr = '0;
    int          hs_cnt = 0;
    logic        pv = 1'b0, pr = 1'b0;
    logic [15:0] pd = '0;
    logic [7:0]  outs;
    int          occ_after;

    always @(negedge clk or posedge rst) begin
        if (rst) begin
            del_ptr = rd_ptr;   // buffered and in-flight words are discarded
            hs_cnt  = 0;
            pv      = 1'b0;
            pr      = 1'b0;
        end else begin
            outs = rd_ptr - del_ptr;
            occ_after = int'(outs) + int'(fifo_rd_en) - int'(m_valid & m_ready);
            check("mon_words_out", words_out, hs_cnt);
            check("mon_rd_while_empty", {31'b0, fifo_rd_en & fifo_empty}, 0);
            check("mon_occupancy_le2", {31'b0, occ_after <= 2}, 1);
            check("mon_idle", {31'b0, idle}, {31'b0, outs == 8'd0});
            check("mon_valid_has_word", {31'b0, m_valid && outs == 8'd0}, 0);
            if (pv && !pr) begin
                check("mon_hold_valid", {31'b0, m_valid}, 1);
                check("mon_hold_data", {16'b0, m_data}, {16'b0, pd});
            end
            if (m_valid && m_ready) begin
                check("mon_order", {16'b0, m_data}, {16'b0, mem[del_ptr]});
                del_ptr = del_ptr + 8'd1;
                hs_cnt++;
            end
            pv = m_valid;
            pr = m_ready;
            pd = m_data;
        end
    end

    // ---------------- Table vectors ----------------------------------------
    typedef struct {
        int   n;
        logic rdy;
        logic en;
        int   exp_rd;
        int   exp_words;
        logic exp_valid;
        logic exp_idle;
    } vec_t;

    vec_t tbl [6];

    initial begin
        int p0;
        int waited;
        logic [15:0] base;

        tbl[0] = '{3, 1'b1, 1'b1, 3, 3, 1'b0, 1'b1};
        tbl[1] = '{5, 1'b0, 1'b1, 2, 0, 1'b1, 1'b0};
        tbl[2] = '{1, 1'b0, 1'b1, 1, 0, 1'b1, 1'b0};
        tbl[3] = '{4, 1'b1, 1'b0, 0, 0, 1'b0, 1'b1};
        tbl[4] = '{0, 1'b1, 1'b1, 0, 0, 1'b0, 1'b1};
        tbl[5] = '{2, 1'b0, 1'b1, 2, 0, 1'b1, 1'b0};

        // Reset held with an empty FIFO and m_ready high.
        m_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            smp();
            check("rst_rd_en", {31'b0, fifo_rd_en}, 0);
            check("rst_valid", {31'b0, m_valid}, 0);
            check("rst_idle", {31'b0, idle}, 1);
            check("rst_words", words_out, 0);
            check("rst_data", {16'b0, m_data}, 0);
            check("rst_err", {31'b0, err_underflow}, 0);
            cyc();
        end

        // Table-driven steady-state vectors.
        for (int i = 0; i < 6; i++) begin
            reset_dut();
            p0 = rd_pulses;
            base = 16'((i + 1) * 16'h100);
            for (int j = 0; j < tbl[i].n; j++) push(base + 16'(j));
            enable = tbl[i].en;
            m_ready = tbl[i].rdy;
            repeat (10) cyc();
            smp();
            check($sformatf("tbl%0d_rd_pulses", i), rd_pulses - p0, tbl[i].exp_rd);
            check($sformatf("tbl%0d_words", i), words_out, tbl[i].exp_words);
            check($sformatf("tbl%0d_valid", i), {31'b0, m_valid}, {31'b0, tbl[i].exp_valid});
            check($sformatf("tbl%0d_idle", i), {31'b0, idle}, {31'b0, tbl[i].exp_idle});
            if (tbl[i].exp_valid)
                check($sformatf("tbl%0d_data", i), {16'b0, m_data}, {16'b0, base});
        end

        // Three words at full rate: exact cycle timing.
        reset_dut();
        push(16'hA1); push(16'hA2); push(16'hA3);
        m_ready = 1'b1;
        enable = 1'b1;
        for (int c = 0; c < 7; c++) begin
            smp();
            check($sformatf("seq3_rd_en_c%0d", c), {31'b0, fifo_rd_en}, {31'b0, c <= 2});
            check($sformatf("seq3_valid_c%0d", c), {31'b0, m_valid}, {31'b0, c >= 2 && c <= 4});
            if (c >= 2 && c <= 4)
                check($sformatf("seq3_data_c%0d", c), {16'b0, m_data}, 32'(16'hA1 + c - 2));
            if (c == 5) begin
                check("seq3_idle_c5", {31'b0, idle}, 1);
                check("seq3_words_c5", words_out, 3);
            end
            cyc();
        end

        // Backpressure: only two reads while stalled, then a clean drain.
        reset_dut();
        p0 = rd_pulses;
        for (int j = 0; j < 5; j++) push(16'hA1 + 16'(j));
        enable = 1'b1;
        m_ready = 1'b0;
        repeat (8) cyc();
        smp();
        check("bp_rd_pulses_stalled", rd_pulses - p0, 2);
        check("bp_valid_stalled", {31'b0, m_valid}, 1);
        check("bp_data_stalled", {16'b0, m_data}, 32'h00A1);
        cyc();
        m_ready = 1'b1;
        repeat (10) cyc();
        smp();
        check("bp_words", words_out, 5);
        check("bp_rd_pulses_total", rd_pulses - p0, 5);
        check("bp_idle", {31'b0, idle}, 1);

        // enable dropped in cycle 3 of a full-rate stream.
        reset_dut();
        for (int j = 0; j < 6; j++) push(16'hC1 + 16'(j));
        enable = 1'b1;
        m_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            if (c == 3) enable = 1'b0;
            smp();
            check($sformatf("endrop_rd_en_c%0d", c), {31'b0, fifo_rd_en}, {31'b0, c < 3});
            cyc();
        end
        repeat (4) cyc();
        smp();
        check("endrop_words", words_out, 3);
        check("endrop_idle", {31'b0, idle}, 1);
        cyc();

        // Sticky underflow error.
        reset_dut();
        smp();
        check("uf_clear_before", {31'b0, err_underflow}, 0);
        cyc();
        fifo_underflow = 1'b1;
        cyc();
        fifo_underflow = 1'b0;
        smp();
        check("uf_set", {31'b0, err_underflow}, 1);
        repeat (5) cyc();
        smp();
        check("uf_sticky", {31'b0, err_underflow}, 1);
        cyc();
        rst = 1'b1;
        #1;
        check("uf_cleared_by_rst", {31'b0, err_underflow}, 0);

        // Asynchronous reset with a full buffer.
        reset_dut();
        for (int j = 0; j < 6; j++) push(16'hB1 + 16'(j));
        enable = 1'b1;
        m_ready = 1'b0;
        repeat (4) cyc();
        m_ready = 1'b1;
        cyc();
        m_ready = 1'b0;
        repeat (3) cyc();
        smp();
        check("ar_pre_valid", {31'b0, m_valid}, 1);
        check("ar_pre_data", {16'b0, m_data}, 32'h00B2);
        check("ar_pre_words", words_out, 1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("ar_valid", {31'b0, m_valid}, 0);
        check("ar_data", {16'b0, m_data}, 0);
        check("ar_words", words_out, 0);
        check("ar_idle", {31'b0, idle}, 1);
        check("ar_rd_en", {31'b0, fifo_rd_en}, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_ready = 1'b1;
        waited = 0;
        smp();
        while (!m_valid && waited < 20) begin
            cyc();
            smp();
            waited++;
        end
        check("ar_post_valid_seen", {31'b0, m_valid}, 1);
        check("ar_post_data", {16'b0, m_data}, 32'h00B4);
        check("ar_post_words0", words_out, 0);
        cyc();
        smp();
        check("ar_post_words1", words_out, 1);
        cyc();

        // Randomized traffic against the scoreboard.
        reset_dut();
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(1, 0) == 1 && 8'(wr_ptr - rd_ptr) < 8'd200)
                push(16'($urandom()));
            m_ready = ($urandom_range(3, 0) != 0);
            enable  = ($urandom_range(7, 0) != 0);
            cyc();
        end
        enable = 1'b1;
        m_ready = 1'b1;
        waited = 0;
        smp();
        while (!(fifo_empty && idle) && waited < 1000) begin
            cyc();
            smp();
            waited++;
        end
        check("rand_drained", {31'b0, fifo_empty && idle}, 1);
        check("rand_all_delivered", {24'b0, del_ptr}, {24'b0, wr_ptr});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
